fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the decoder. It owns the program counter and issues word-aligned requests to instruction memory, with at most one request outstanding at a time. Returned words are buffered, paired with their PC, in a small FIFO. The FIFO presents `{pc, instr}` to the decoder over a valid/ready handshake, and the whole stage is flushed by a redirect from the execute stage.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM states, buffered entry layout, JAL decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // J-type immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} with imm[0] = 0
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, instr} entries; head is read straight from storage.
// Latency: a push is visible at the head one cycle later; pop takes effect at the edge.
// Backpressure: full blocks push unless a pop happens in the same cycle; flush empties it.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    fetch_entry_t mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage, one imem request in flight, buffered {pc, instr} to decode; FETCH_JAL_PREDICT_EN enables JAL-target fetch.
// Latency: request accepted at N, response at N+k, entry on if_valid at N+k+1.
// Backpressure: requests stall while the buffer is full; redirect flushes and drains the in-flight response.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  req_pc, req_pc_nxt;
    logic         push;
    logic         full;
    logic         empty;
    fetch_entry_t push_dat;
    fetch_entry_t head;

    assign imem_req_addr = pc;
    assign push_dat      = '{pc: req_pc, instr: imem_resp_data};
    assign if_valid      = !empty;
    assign if_instr      = head.instr;
    assign if_pc         = head.pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            req_pc <= req_pc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        req_pc_nxt     = req_pc;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        case (state)
            IDLE: begin
                imem_req_valid = rst_n && !full && !redirect_valid;
                if (imem_req_valid && imem_req_ready) begin
                    pc_nxt     = pc + 32'd4;
                    req_pc_nxt = pc;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
`ifdef FETCH_JAL_PREDICT_EN
                    if (imem_resp_data[6:0] == OPC_JAL) begin
                        pc_nxt = req_pc + j_imm(imem_resp_data);
                    end
`endif
                end
            end
            DRAIN: begin
                if (imem_resp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Redirect beats everything; a response landing in the same cycle is dropped.
        if (redirect_valid) begin
            push   = 1'b0;
            pc_nxt = {redirect_pc[31:2], 2'b00};
            if (state == IDLE || imem_resp_valid) begin
                state_nxt = IDLE;
            end else begin
                state_nxt = DRAIN;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (if_valid && if_ready),
        .flush    (redirect_valid),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

endmodule
